// File: rtl/lockable_reg_bank.sv
// Bank of NUM_CH configuration registers with sticky per-channel write locks,
// plus a key-authenticated debug session that bypasses the locks until exit.
//
// Debug FSM
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_LOCKED    | normal operation, locks enforced, key attempts counted
//   ST_UNLOCKED  | debug session open, writes bypass lock bits
//   ST_LOCKOUT   | too many bad keys, debug unlock disabled until reset
module lockable_reg_bank #(
    parameter int                DATA_W    = 16,
    parameter int                NUM_CH    = 4,
    parameter int                ADDR_W    = $clog2(NUM_CH),
    parameter int                KEY_W     = 32,
    parameter logic [KEY_W-1:0]  DBG_KEY   = 32'hA5C3_5A3C,
    parameter int                MAX_TRIES = 3
) (
    input  logic              Clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0] lock_set,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              dbg_req,
    input  logic [KEY_W-1:0]  dbg_key,
    input  logic              dbg_exit,
    output logic [NUM_CH-1:0] lock_status,
    output logic              dbg_unlocked,
    output logic              dbg_lockout,
    output logic              wr_err
);

    localparam int               FAIL_W   = $clog2(MAX_TRIES + 1);
    localparam logic [FAIL_W-1:0] MAX_FAIL = FAIL_W'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } dbg_state_t;

    dbg_state_t          state;
    dbg_state_t          state_nxt;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [FAIL_W-1:0]   fail_cnt_inc;
    logic                key_match;

    logic [DATA_W-1:0]   regs [NUM_CH];
    logic [NUM_CH-1:0]   wr_sel;
    logic                wr_in_range;
    logic                wr_locked;
    logic                wr_accept;
    logic [DATA_W-1:0]   rd_next;

    // ------------------------------------------------------------------
    // Address decode: one-hot select, empty when the address is past the bank
    // ------------------------------------------------------------------
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = ({1'b0, wr_addr} == (ADDR_W + 1)'(i));
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ({1'b0, rd_addr} == (ADDR_W + 1)'(i)) begin
                rd_next = regs[i];
            end
        end
    end

    assign wr_in_range = |wr_sel;
    assign wr_locked   = |(wr_sel & lock_status);
    // dbg_unlocked is a registered state decode, so a key accepted this
    // cycle cannot open a write in the same cycle.
    assign wr_accept   = wr_en & wr_in_range & (~wr_locked | dbg_unlocked);

    // ------------------------------------------------------------------
    // Register array, locks, read port, write error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_accept && wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            lock_status <= '0;
            rd_data     <= '0;
            wr_err      <= 1'b0;
        end else begin
            lock_status <= lock_status | lock_set;
            rd_data     <= rd_next;
            wr_err      <= wr_en & ~wr_accept;
        end
    end

    // ------------------------------------------------------------------
    // Debug unlock FSM
    // ------------------------------------------------------------------
    assign key_match    = (dbg_key == DBG_KEY);
    assign fail_cnt_inc = fail_cnt + FAIL_W'(1);

    always_ff @(posedge Clk) begin
        if (!resetn) begin
            state <= ST_LOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOCKED: begin
                if (dbg_req) begin
                    if (key_match) begin
                        state_nxt = ST_UNLOCKED;
                    end else if (fail_cnt_inc == MAX_FAIL) begin
                        state_nxt = ST_LOCKOUT;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (dbg_exit || (|lock_set)) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                state_nxt = ST_LOCKOUT;
            end
            default: begin
                state_nxt = ST_LOCKED;
            end
        endcase
    end

    always_comb begin
        dbg_unlocked = 1'b0;
        dbg_lockout  = 1'b0;
        case (state)
            ST_UNLOCKED: dbg_unlocked = 1'b1;
            ST_LOCKOUT:  dbg_lockout  = 1'b1;
            default: begin
                dbg_unlocked = 1'b0;
                dbg_lockout  = 1'b0;
            end
        endcase
    end

    // Failed-attempt counter saturates at MAX_TRIES rather than wrapping
    always_ff @(posedge Clk) begin
        if (!resetn) begin
            fail_cnt <= '0;
        end else if ((state == ST_LOCKED) && dbg_req) begin
            if (key_match) begin
                fail_cnt <= '0;
            end else if (fail_cnt != MAX_FAIL) begin
                fail_cnt <= fail_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Bench for lockable_reg_bank: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the register bank.
module tb_lockable_reg_bank;

    // Five channels so that out-of-range write/read addresses are reachable
    localparam int               DATA_W    = 16;
    localparam int               NUM_CH    = 5;
    localparam int               ADDR_W    = $clog2(NUM_CH);
    localparam int               KEY_W     = 32;
    localparam logic [KEY_W-1:0] DBG_KEY   = 32'hA5C3_5A3C;
    localparam int               MAX_TRIES = 3;

    logic              Clk = 1'b0;
    logic              resetn;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_CH-1:0] lock_set;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              dbg_req;
    logic [KEY_W-1:0]  dbg_key;
    logic              dbg_exit;
    logic [NUM_CH-1:0] lock_status;
    logic              dbg_unlocked;
    logic              dbg_lockout;
    logic              wr_err;

    lockable_reg_bank #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .KEY_W(KEY_W),
        .DBG_KEY(DBG_KEY), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .Clk(Clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .lock_set(lock_set), .rd_addr(rd_addr),
        .rd_data(rd_data), .dbg_req(dbg_req), .dbg_key(dbg_key),
        .dbg_exit(dbg_exit), .lock_status(lock_status),
        .dbg_unlocked(dbg_unlocked), .dbg_lockout(dbg_lockout), .wr_err(wr_err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: plain arrays and a session mode
    localparam int MODE_NORMAL  = 0;
    localparam int MODE_SESSION = 1;
    localparam int MODE_BANNED  = 2;

    int                m_reg [NUM_CH];
    bit                m_lock [NUM_CH];
    int                m_mode;
    int                m_fails;
    int                m_rd;
    bit                m_err;

    function automatic logic [NUM_CH-1:0] model_lock_vec();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_lock[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_reg[i]  = 0;
            m_lock[i] = 0;
        end
        m_mode  = MODE_NORMAL;
        m_fails = 0;
        m_rd    = 0;
        m_err   = 0;
    endtask

    // One clock: model computes from pre-edge inputs/state, then compare
    task automatic cycle();
        int  wa, ra, nxt_rd, nxt_mode, nxt_fails;
        bit  ok, nxt_err;
        wa = int'(wr_addr);
        ra = int'(rd_addr);
        if (!resetn) begin
            @(posedge Clk);
            #1;
            model_reset();
        end else begin
            ok      = wr_en && (wa < NUM_CH) && (!m_lock[wa] || m_mode == MODE_SESSION);
            nxt_err = wr_en && !ok;
            nxt_rd  = (ra < NUM_CH) ? m_reg[ra] : 0;
            nxt_mode  = m_mode;
            nxt_fails = m_fails;
            if (m_mode == MODE_NORMAL && dbg_req) begin
                if (dbg_key == DBG_KEY) begin
                    nxt_mode  = MODE_SESSION;
                    nxt_fails = 0;
                end else begin
                    nxt_fails = (m_fails + 1 > MAX_TRIES) ? MAX_TRIES : m_fails + 1;
                    if (m_fails + 1 == MAX_TRIES) nxt_mode = MODE_BANNED;
                end
            end else if (m_mode == MODE_SESSION && (dbg_exit || lock_set != 0)) begin
                nxt_mode = MODE_NORMAL;
            end
            @(posedge Clk);
            #1;
            if (ok) m_reg[wa] = int'(wr_data);
            for (int i = 0; i < NUM_CH; i++) if (lock_set[i]) m_lock[i] = 1;
            m_err   = nxt_err;
            m_rd    = nxt_rd;
            m_mode  = nxt_mode;
            m_fails = nxt_fails;
        end
        check_val("rd_data",      32'(rd_data),      32'(m_rd));
        check_val("wr_err",       32'(wr_err),       32'(m_err));
        check_val("lock_status",  32'(lock_status),  32'(model_lock_vec()));
        check_val("dbg_unlocked", 32'(dbg_unlocked), 32'(m_mode == MODE_SESSION));
        check_val("dbg_lockout",  32'(dbg_lockout),  32'(m_mode == MODE_BANNED));
    endtask

    task automatic idle_inputs();
        resetn   = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        lock_set = '0;
        rd_addr  = '0;
        dbg_req  = 1'b0;
        dbg_key  = '0;
        dbg_exit = 1'b0;
    endtask

    task automatic do_write(input int ch, input logic [DATA_W-1:0] d);
        idle_inputs();
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(ch);
        wr_data = d;
        cycle();
    endtask

    task automatic do_read(input int ch);
        idle_inputs();
        rd_addr = ADDR_W'(ch);
        cycle();
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // T1
        do_reset();
        check_val("t1_reset_rd", 32'(rd_data), 32'h0);
        check_val("t1_reset_lock", 32'(lock_status), 32'h0);
        do_write(2, 16'h1234);
        check_val("t1_wr_err", 32'(wr_err), 32'h0);
        do_read(2);
        check_val("t1_rd_ch2", 32'(rd_data), 32'h1234);

        // T2
        idle_inputs(); lock_set = 5'b00100; cycle();
        check_val("t2_lock", 32'(lock_status), 32'h4);
        do_write(2, 16'hBEEF);
        check_val("t2_wr_err", 32'(wr_err), 32'h1);
        do_write(1, 16'h1111);
        check_val("t2_err_drop", 32'(wr_err), 32'h0);
        do_read(2);
        check_val("t2_ch2_kept", 32'(rd_data), 32'h1234);
        do_read(1);
        check_val("t2_ch1_wr", 32'(rd_data), 32'h1111);

        // T3
        idle_inputs(); dbg_req = 1'b1; dbg_key = DBG_KEY; cycle();
        check_val("t3_unlocked", 32'(dbg_unlocked), 32'h1);
        do_write(2, 16'hBEEF);
        check_val("t3_dbg_wr", 32'(wr_err), 32'h0);
        idle_inputs(); dbg_exit = 1'b1; cycle();
        check_val("t3_exit", 32'(dbg_unlocked), 32'h0);
        do_write(2, 16'h0001);
        check_val("t3_rejected", 32'(wr_err), 32'h1);
        do_read(2);
        check_val("t3_ch2", 32'(rd_data), 32'hBEEF);

        // T4
        for (int k = 0; k < 3; k++) begin
            idle_inputs(); dbg_req = 1'b1; dbg_key = DBG_KEY ^ 32'(k + 1); cycle();
            check_val("t4_lockout", 32'(dbg_lockout), 32'(k == 2));
        end
        idle_inputs(); dbg_req = 1'b1; dbg_key = DBG_KEY; cycle();
        check_val("t4_no_unlock", 32'(dbg_unlocked), 32'h0);
        do_reset();
        check_val("t4_rst_lockout", 32'(dbg_lockout), 32'h0);
        check_val("t4_rst_lock", 32'(lock_status), 32'h0);
        do_read(2);
        check_val("t4_rst_ch2", 32'(rd_data), 32'h0);

        // T5
        idle_inputs(); lock_set = 5'b00001; wr_en = 1'b1; wr_addr = '0; wr_data = 16'h00AA; cycle();
        check_val("t5_same_cycle", 32'(wr_err), 32'h0);
        do_write(0, 16'h0055);
        check_val("t5_next_rej", 32'(wr_err), 32'h1);
        do_read(0);
        check_val("t5_ch0", 32'(rd_data), 32'h00AA);

        // T6, including a write in the same cycle as the correct key
        idle_inputs(); lock_set = 5'b00100; cycle();
        idle_inputs(); dbg_req = 1'b1; dbg_key = DBG_KEY;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7777; cycle();
        check_val("t6_key_wr_blk", 32'(wr_err), 32'h1);
        check_val("t6_unlocked", 32'(dbg_unlocked), 32'h1);
        idle_inputs(); lock_set = 5'b01000; cycle();
        check_val("t6_lock_exit", 32'(dbg_unlocked), 32'h0);
        do_write(2, 16'h2222);
        check_val("t6_ch2_rej", 32'(wr_err), 32'h1);
        do_write(6, 16'h3333);
        check_val("t6_oob_err", 32'(wr_err), 32'h1);
        do_read(7);
        check_val("t6_oob_rd", 32'(rd_data), 32'h0);

        // Random traffic in epochs, each starting from reset
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                idle_inputs();
                wr_en    = ($urandom_range(0, 99) < 60);
                wr_addr  = ADDR_W'($urandom_range(0, 7));
                wr_data  = DATA_W'($urandom());
                rd_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 7));
                if ($urandom_range(0, 24) == 0) lock_set = NUM_CH'(1 << $urandom_range(0, NUM_CH - 1));
                if ($urandom_range(0, 7) == 0) begin
                    dbg_req = 1'b1;
                    dbg_key = ($urandom_range(0, 1) == 1) ? DBG_KEY : (DBG_KEY ^ (32'($urandom()) | 32'h1));
                end
                dbg_exit = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 149) == 0) resetn = 1'b0;
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
